// File: rtl/fir_decim_mac.sv
// -----------------------------------------------------------------------------
// fir_decim_mac
//   Decimating FIR channel filter for the FM receive chain. Samples, taps and
//   the output are Q22.10 signed. After every DECIM accepted samples the block
//   runs one NUM_TAPS-point convolution through a single multiplier, one tap
//   per clock, and presents the result on a valid/ready output port.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   upstream sample valid
//   in_ready   block can accept a sample (high only while idle)
//   in_data    sample x[n], Q22.10
//   coef_wr    coefficient write strobe (honoured only while idle)
//   coef_addr  tap index k
//   coef_data  h[k], Q22.10
//   out_valid  filtered sample valid
//   out_ready  downstream accepts
//   out_data   y, Q22.10 (zero while out_valid is low)
// -----------------------------------------------------------------------------
module fir_decim_mac #(
  parameter  int NUM_TAPS = 16,
  parameter  int DECIM    = 4,
  parameter  int DATA_W   = 32,
  localparam int AW       = $clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              coef_wr,
  input  logic [AW-1:0]     coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int FRAC = 10;
  localparam int TW   = $clog2(NUM_TAPS + 1);
  localparam int DW   = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] hist [NUM_TAPS];
  logic [DATA_W-1:0] coef [NUM_TAPS];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DW-1:0]     decim_cnt;
  logic [TW-1:0]     tap;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] prod_q;

  logic                       accept;
  logic                       trigger;
  logic                       mac_last;
  logic                       coef_hit;
  logic signed [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]          term;
  logic                       unused_prod;

  assign accept   = (state == IDLE) && in_valid;
  assign trigger  = accept && (decim_cnt == DW'(DECIM - 1));
  assign coef_hit = coef_wr && (32'(coef_addr) < NUM_TAPS);

  // tap counts 0..NUM_TAPS: products are registered, so the final cycle only
  // folds the last product into acc. The tap index into coef[] is unused then.
  assign mac_last = (tap == TW'(NUM_TAPS));

  // Full signed product; keeping bits [FRAC+DATA_W-1:FRAC] is an arithmetic
  // shift (floor) followed by a 32-bit wrap.
  assign product     = $signed(coef[tap[AW-1:0]]) * $signed(hist[rd_ptr]);
  assign term        = product[FRAC +: DATA_W];
  assign unused_prod = ^{product[2*DATA_W-1:FRAC+DATA_W], product[FRAC-1:0]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (trigger)   state_nxt = MAC;
      MAC:     if (mac_last)  state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: sample history, coefficient store, MAC pipeline
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge value of its neighbours (rd_ptr, tap and acc update together).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: both arrays are cleared because the filter must start with a zero
      // history window and zero taps; this forces them into flops, not RAM.
      for (int i = 0; i < NUM_TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      decim_cnt <= '0;
      tap       <= '0;
      acc       <= '0;
      prod_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_hit) coef[coef_addr] <= coef_data;
          if (accept) begin
            hist[wr_ptr] <= in_data;
            wr_ptr <= (wr_ptr == AW'(NUM_TAPS - 1)) ? '0 : wr_ptr + AW'(1);
            if (trigger) begin
              decim_cnt <= '0;
              acc       <= '0;
              tap       <= '0;
              // Newest sample sits at the slot being written now; walk backwards.
              rd_ptr    <= wr_ptr;
            end else begin
              decim_cnt <= decim_cnt + DW'(1);
            end
          end
        end
        MAC: begin
          if (!mac_last) begin
            prod_q <= term;
            rd_ptr <= (rd_ptr == '0) ? AW'(NUM_TAPS - 1) : rd_ptr - AW'(1);
            tap    <= tap + TW'(1);
          end
          // prod_q holds a valid product from the second MAC cycle onward.
          if (tap != '0) acc <= acc + prod_q;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign out_data  = out_valid ? acc : '0;

endmodule

// File: tb/tb_fir_decim_mac.sv
// -----------------------------------------------------------------------------
// tb_fir_decim_mac
//   Self-checking bench for fir_decim_mac. Expected outputs are pushed to a
//   queue when the triggering sample is accepted and popped by a monitor when
//   the DUT transfers an output. Expectations come either from hand-derived
//   tables or from a small behavioural model of the filter.
// -----------------------------------------------------------------------------
module tb_fir_decim_mac;

  localparam int NUM_TAPS = 16;
  localparam int DECIM    = 4;
  localparam int AW       = $clog2(NUM_TAPS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          coef_wr = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [31:0]   coef_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;

  fir_decim_mac #(.NUM_TAPS(NUM_TAPS), .DECIM(DECIM), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  logic [31:0] exp_q[$];

  // Behavioural model state
  int mh[NUM_TAPS];
  int mcoef[NUM_TAPS];
  int mptr = 0;
  int mcnt = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;   // expected output, used only on every DECIM-th sample
  } vec_t;

  vec_t imp_tab[20];
  vec_t dc_tab[24];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // y = sum_k h[k]*x[n-k], each term floor(product/1024) wrapped to 32 bits.
  function automatic logic [31:0] model_y();
    logic [31:0] a;
    longint      p;
    logic [63:0] q;
    a = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      p = longint'(mcoef[k]) * longint'(mh[(mptr - k + NUM_TAPS) % NUM_TAPS]);
      q = p >>> 10;
      a = a + q[31:0];
    end
    return a;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_TAPS; i++) begin
      mh[i]    = 0;
      mcoef[i] = 0;
    end
    mptr = 0;
    mcnt = 0;
    exp_q.delete();
  endtask

  // Output monitor: compare every transferred output against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        check($sformatf("out%0d", n_out), out_data, exp_q.pop_front());
      end
      n_out++;
    end
  end

  task automatic write_coef(input int addr, input logic [31:0] data, input bit taken);
    coef_wr   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = data;
    @(posedge clk); #1;
    coef_wr = 1'b0;
    if (taken) mcoef[addr] = int'(data);
  endtask

  task automatic send_sample(input logic [31:0] x, input bit use_exp, input logic [31:0] exp_y);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      fail("in_ready_wait");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    mh[mptr] = int'(x);
    if (mcnt == DECIM - 1) begin
      mcnt = 0;
      exp_q.push_back(use_exp ? exp_y : model_y());
    end else begin
      mcnt++;
    end
    mptr = (mptr + 1) % NUM_TAPS;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !in_ready) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || !in_ready) begin
      fail("idle_wait");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_bad;

    // Impulse through h[k]=(k+1)<<10: the impulse walks across taps 3,7,11,15.
    for (int i = 0; i < 20; i++) imp_tab[i] = '{x: 32'd0, y: 32'd0};
    imp_tab[0].x  = 32'd1024;
    imp_tab[3].y  = 32'd4096;
    imp_tab[7].y  = 32'd8192;
    imp_tab[11].y = 32'd12288;
    imp_tab[15].y = 32'd16384;
    imp_tab[19].y = 32'd0;

    // DC input 1.0 through 16 taps of 64: window fills 4 samples per output.
    for (int i = 0; i < 24; i++) dc_tab[i] = '{x: 32'd1024, y: 32'd0};
    dc_tab[3].y  = 32'd256;
    dc_tab[7].y  = 32'd512;
    dc_tab[11].y = 32'd768;
    dc_tab[15].y = 32'd1024;
    dc_tab[19].y = 32'd1024;
    dc_tab[23].y = 32'd1024;

    model_clear();

    // ---- reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data",  out_data,           32'd0);
    @(posedge clk); #1;

    // ---- impulse response
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 32'((k + 1) << 10), 1'b1);
    for (int i = 0; i < 20; i++) send_sample(imp_tab[i].x, 1'b1, imp_tab[i].y);
    wait_idle();

    // ---- DC gain
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 32'd64, 1'b1);
    for (int i = 0; i < 24; i++) send_sample(dc_tab[i].x, 1'b1, dc_tab[i].y);
    wait_idle();

    // ---- rounding and sign: floor of a negative sub-LSB product is -1 LSB
    write_coef(0, 32'hFFFF_FFFF, 1'b1);
    for (int k = 1; k < NUM_TAPS; k++) write_coef(k, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) send_sample(32'd1024, 1'b1, 32'd0);
    send_sample(32'd1, 1'b1, 32'hFFFF_FFFF);
    wait_idle();
    write_coef(0, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 3; i++) send_sample(32'd1024, 1'b1, 32'd0);
    send_sample(32'd1, 1'b1, 32'd0);
    wait_idle();

    // ---- latency and backpressure
    write_coef(0, 32'd1024, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_sample(32'd0, 1'b1, 32'd0);
    send_sample(32'h0000_1234, 1'b1, 32'h0000_1234);
    repeat (NUM_TAPS + 1) @(negedge clk);
    check("lat_early",   {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_on_time", {31'b0, out_valid}, 32'd1);
    hold_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_data !== exp_q[0]) hold_bad++;
    end
    check("hold_stable", 32'(hold_bad), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("release_out_valid", {31'b0, out_valid}, 32'd0);
    check("release_in_ready",  {31'b0, in_ready},  32'd1);
    out_ready = 1'b1;
    wait_idle();

    // ---- reset in the middle of MAC clears taps and history
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 32'((k + 1) << 10), 1'b1);
    send_sample(32'd1024, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) send_sample(32'd512, 1'b0, 32'd0);
    @(negedge clk);                 // tap 0
    repeat (5) @(negedge clk);      // tap 5
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) send_sample(imp_tab[i].x, 1'b1, 32'd0);
    wait_idle();

    // ---- coefficient write during MAC is dropped, repeated in IDLE it lands
    write_coef(0, 32'd1024, 1'b1);
    send_sample(32'd10, 1'b0, 32'd0);
    send_sample(32'd20, 1'b0, 32'd0);
    send_sample(32'd30, 1'b0, 32'd0);
    send_sample(32'd1000, 1'b0, 32'd0);
    write_coef(0, 32'h7FFF_FFFF, 1'b0);
    send_sample(32'd5, 1'b0, 32'd0);
    send_sample(32'd6, 1'b0, 32'd0);
    send_sample(32'd7, 1'b0, 32'd0);
    send_sample(32'd2048, 1'b0, 32'd0);
    wait_idle();
    write_coef(0, 32'h7FFF_FFFF, 1'b1);
    send_sample(32'd1, 1'b0, 32'd0);
    send_sample(32'd2, 1'b0, 32'd0);
    send_sample(32'd3, 1'b0, 32'd0);
    send_sample(32'd1024, 1'b0, 32'd0);
    wait_idle();

    // ---- random taps and samples against the model
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, $urandom, 1'b1);
    for (int i = 0; i < 12; i++) send_sample($urandom, 1'b0, 32'd0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
